// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative signed multiply/divide sequencer.
package multdiv_pkg;

   localparam int DEF_WIDTH = 32;

   typedef logic [1:0] state_t;
   localparam state_t IDLE   = 2'd0;
   localparam state_t MULT   = 2'd1;
   localparam state_t DIV    = 2'd2;
   localparam state_t FINISH = 2'd3;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } op_t;

   localparam logic [DEF_WIDTH-1:0] MIN_NEG = 32'h8000_0000;

endpackage

// File: rtl/mult_range_check.sv
// Flags a signed double-width product that does not fit in WIDTH bits,
// i.e. the upper WIDTH+1 bits are not all copies of the sign.
module mult_range_check
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)
(
   input  logic [2*WIDTH-1:0] product,
   output logic               overflow
);

   assign overflow = (product != {{WIDTH{product[WIDTH-1]}}, product[WIDTH-1:0]});

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply/divide: WIDTH shift-add or restoring-divide steps
// on operand magnitudes, then one FINISH cycle that applies the sign.
//
//   state  | meaning
//   IDLE   | waiting for ctrl_MULT / ctrl_DIV
//   MULT   | one multiplier bit per cycle into the accumulator
//   DIV    | one quotient bit per cycle (restoring)
//   FINISH | sign fix-up, register result/exception, pulse data_resultRDY
module multdiv_sequencer
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int              CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] NEG_LIMIT = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state;
   op_t                op;
   logic [CNT_W-1:0]   counter;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc;
   logic               neg_result;
   logic               div_zero;
   logic               div_ovf;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH:0]     mult_sum;
   logic [2*WIDTH-1:0] mult_next;
   logic [WIDTH:0]     div_shift;
   logic               div_fits;
   logic [WIDTH-1:0]   div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quotient;
   logic               mult_ovf;
   logic [WIDTH-1:0]   fin_result;
   logic               fin_exc;
   logic               last_iter;

   assign mag_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign mag_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   assign acc_hi = acc[2*WIDTH-1:WIDTH];
   assign acc_lo = acc[WIDTH-1:0];

   // Multiply: acc_hi accumulates, acc_lo holds the not-yet-consumed multiplier bits.
   assign mult_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
   assign mult_next = {mult_sum, acc_lo[WIDTH-1:1]};

   // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
   // When the trial subtract fits, the true difference is below the divisor, so WIDTH bits suffice.
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_fits  = (div_shift >= {1'b0, opnd});
   assign div_diff  = div_shift[WIDTH-1:0] - opnd;
   assign div_next  = div_fits ? {div_diff, acc_lo[WIDTH-2:0], 1'b1}
                               : {div_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};

   assign product   = neg_result ? -acc : acc;
   assign quotient  = neg_result ? -acc_lo : acc_lo;
   assign last_iter = (counter == CNT_LAST);

   mult_range_check #(
      .WIDTH    (WIDTH)
   ) u_range_check (
      .product  (product),
      .overflow (mult_ovf)
   );

   always_comb begin
      fin_result = product[WIDTH-1:0];
      fin_exc    = mult_ovf;
      if (op == OP_DIV) begin
         fin_result = div_zero ? {WIDTH{1'b0}} : quotient;
         fin_exc    = div_zero | div_ovf;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         op             <= OP_MULT;
         counter        <= '0;
         opnd           <= '0;
         acc            <= '0;
         neg_result     <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
         busy           <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            IDLE: begin
               if (ctrl_MULT || ctrl_DIV) begin
                  counter    <= '0;
                  busy       <= 1'b1;
                  neg_result <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                  div_zero   <= (data_operandB == {WIDTH{1'b0}});
                  div_ovf    <= (data_operandA == NEG_LIMIT) && (data_operandB == {WIDTH{1'b1}});
                  if (ctrl_MULT) begin
                     op    <= OP_MULT;
                     state <= MULT;
                     opnd  <= mag_a;
                     acc   <= {{WIDTH{1'b0}}, mag_b};
                  end else begin
                     op    <= OP_DIV;
                     state <= DIV;
                     opnd  <= mag_b;
                     acc   <= {{WIDTH{1'b0}}, mag_a};
                  end
               end
            end
            MULT: begin
               acc     <= mult_next;
               counter <= counter + CNT_W'(1);
               if (last_iter) state <= FINISH;
            end
            DIV: begin
               acc     <= div_next;
               counter <= counter + CNT_W'(1);
               if (last_iter) state <= FINISH;
            end
            FINISH: begin
               data_result    <= fin_result;
               data_exception <= fin_exc;
               data_resultRDY <= 1'b1;
               busy           <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: vector table, scoreboard of expected
// completions, and hand sequences for arbitration, back-to-back and reset.
module tb_multdiv_sequencer;
   import multdiv_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   typedef struct {
      logic        m;
      logic        d;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        e;
   } vec_t;

   typedef struct {
      logic [31:0] r;
      logic        e;
      int          edge_no;
   } exp_t;

   exp_t sb[$];
   exp_t mon_x;
   int   checks = 0;
   int   failures = 0;
   int   edge_cnt = 0;
   int   strobe_cnt = 0;
   logic prev_rdy = 1'b0;

   multdiv_sequencer #(.WIDTH(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   always @(posedge clock) edge_cnt++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Completion monitor: every strobe must match the oldest pending expectation.
   always @(negedge clock) begin
      if (data_resultRDY) begin
         strobe_cnt++;
         chk("strobe_one_cycle", 64'(prev_rdy), 64'd0);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual_result=%0h expected=no_strobe", data_result);
         end else begin
            mon_x = sb.pop_front();
            chk("result", 64'(data_result), 64'(mon_x.r));
            chk("exception", 64'(data_exception), 64'(mon_x.e));
            chk("latency_edge", 64'(edge_cnt), 64'(mon_x.edge_no));
         end
      end
      prev_rdy = data_resultRDY;
   end

   function automatic void model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint            p;
      logic signed [31:0] q;
      r = '0;
      e = 1'b0;
      if (m) begin
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         e = (p != longint'($signed(p[31:0])));
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (a == MIN_NEG && b == 32'hFFFF_FFFF) begin
         r = MIN_NEG;
         e = 1'b1;
      end else begin
         q = $signed(a) / $signed(b);
         r = q;
         e = 1'b0;
      end
   endfunction

   task automatic push_exp(input logic [31:0] r, input logic e);
      exp_t x;
      x.r = r;
      x.e = e;
      x.edge_no = edge_cnt + 33;
      sb.push_back(x);
   endtask

   task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic e);
      @(negedge clock);
      ctrl_MULT = m;
      ctrl_DIV = d;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      push_exp(r, e);
      chk("busy_after_start", 64'(busy), 64'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 80) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL completion_timeout pending=%0d expected=0", sb.size());
         sb.delete();
      end else begin
         chk("busy_after_done", 64'(busy), 64'd0);
      end
   endtask

   vec_t tbl[16];
   int   s0;
   int   bad;
   logic found;
   logic [31:0] ra, rb, rr;
   logic        rm, re;

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
      tbl[2]  = '{1'b1, 1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 32'd3,          32'd4,         32'd12,        1'b0};
      tbl[8]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 32'd0,          32'h8000_0000, 32'h0000_0000, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 32'h7FFF_FFFF,  32'd2,         32'h3FFF_FFFF, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 32'd0,          32'd0,         32'h0000_0000, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         1'b0};
      tbl[14] = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 32'h0000_FFFF,  32'h0000_FFFF, 32'hFFFE_0001, 1'b1};

      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = 32'd0;
      data_operandB = 32'd0;
      reset = 1'b1;
      #1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_rdy", 64'(data_resultRDY), 64'd0);
      chk("reset_result", 64'(data_result), 64'd0);
      chk("reset_exception", 64'(data_exception), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // busy profile of the first multiply: high on edges 1..32, strobe at 33 only
      start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
      @(negedge clock);
      bad = 0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clock);
         if (busy !== 1'b1 || data_resultRDY !== 1'b0) bad++;
      end
      chk("busy_window_bad_cycles", 64'(bad), 64'd0);
      @(negedge clock);
      chk("rdy_at_edge33", 64'(data_resultRDY), 64'd1);
      chk("busy_at_edge33", 64'(busy), 64'd0);
      @(negedge clock);
      chk("rdy_after_edge34", 64'(data_resultRDY), 64'd0);
      wait_done();

      for (int i = 0; i < 16; i++) begin
         start_op(tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].e);
         wait_done();
      end

      for (int i = 0; i < 10; i++) begin
         rm = 1'(($urandom % 2));
         ra = $urandom;
         rb = (($urandom % 4) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         model(rm, ra, rb, rr, re);
         start_op(rm, ~rm, ra, rb, rr, re);
         wait_done();
      end

      // Arbitration plus a DIV pulse at edge 10 that must be ignored
      s0 = strobe_cnt;
      start_op(1'b1, 1'b1, 32'd3, 32'd4, 32'd12, 1'b0);
      repeat (9) @(posedge clock);
      @(negedge clock);
      ctrl_DIV = 1'b1;
      data_operandA = 32'd5;
      data_operandB = 32'd0;
      @(posedge clock);
      #1;
      ctrl_DIV = 1'b0;
      wait_done();
      repeat (40) @(negedge clock);
      chk("ignored_pulse_strobes", 64'(strobe_cnt - s0), 64'd1);

      // Back-to-back: new start sampled on the edge that drops the strobe
      start_op(1'b1, 1'b0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0);
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge clock);
         if (data_resultRDY) found = 1'b1;
      end
      chk("b2b_first_strobe_seen", 64'(found), 64'd1);
      ctrl_MULT = 1'b1;
      data_operandA = 32'hFFFF_FFFD;
      data_operandB = 32'd5;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      push_exp(32'hFFFF_FFF1, 1'b0);
      chk("b2b_busy_after_start", 64'(busy), 64'd1);
      wait_done();

      // Leave a nonzero result with exception set, then reset mid-multiply
      start_op(1'b1, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 1'b1);
      wait_done();
      start_op(1'b1, 1'b0, 32'd9, 32'd9, 32'd81, 1'b0);
      repeat (10) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_busy", 64'(busy), 64'd0);
      chk("async_reset_rdy", 64'(data_resultRDY), 64'd0);
      chk("async_reset_result", 64'(data_result), 64'd0);
      chk("async_reset_exception", 64'(data_exception), 64'd0);
      sb.delete();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      s0 = strobe_cnt;
      repeat (40) @(negedge clock);
      chk("no_strobe_after_reset", 64'(strobe_cnt - s0), 64'd0);
      start_op(1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0);
      wait_done();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
